// File: rtl/maze_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : maze_mem_pkg
//  Description : Shared definitions for maze/screen storage: the controller
//                FSM state encoding and the default memory geometry used by
//                both the dual-port RAM controller and the maze renderer.
//  Revision    : 1.0  initial release
// ============================================================================
package maze_mem_pkg;

    // Default geometry, shared with the renderer
    localparam int MAZE_DATA_W = 16;
    localparam int MAZE_ADDR_W = 9;
    localparam int MAZE_DEPTH  = 512;

    // Controller FSM encoding
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } maze_state_e;

endpackage : maze_mem_pkg
`default_nettype wire

// File: rtl/maze_dpram_core.sv
`default_nettype none
// ============================================================================
//  Module      : maze_dpram_core
//  Description : Bare inferred true dual-port RAM, one clock. Each port has
//                a synchronous read (read-first) and a synchronous write.
//                When both ports write the same word, port A lands last and
//                therefore wins.
//  Ports       : clk          - clock
//                a_re_i/b_re_i       - read enable per port
//                a_we_i/b_we_i       - write enable per port
//                a_addr_i/b_addr_i   - word address per port
//                a_wdata_i/b_wdata_i - write data per port
//                a_rdata_o/b_rdata_o - registered read data per port
//  Revision    : 1.0  initial release
// ============================================================================
module maze_dpram_core #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              a_re_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic [DATA_W-1:0] a_rdata_o,
    input  logic              b_re_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic [DATA_W-1:0] b_rdata_o
);

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    // Both writes live in one process so the array has a single driver;
    // port A is written second so it takes priority on a shared address.
    always_ff @(posedge clk) begin
        if (b_we_i) begin
            mem_q[b_addr_i] <= b_wdata_i;
        end
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_wdata_i;
        end
    end

    // Non-blocking update means a same-cycle write is not yet visible: read-first
    always_ff @(posedge clk) begin
        if (a_re_i) begin
            a_rdata_q <= mem_q[a_addr_i];
        end
        if (b_re_i) begin
            b_rdata_q <= mem_q[b_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule : maze_dpram_core
`default_nettype wire

// File: rtl/maze_dpram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : maze_dpram_ctrl
//  Description : Dual-port maze/screen RAM with a power-up / on-demand clear
//                FSM, deterministic same-address collision handling and a
//                port-B auto-increment scan mode for raster readout.
//                Optional feature macro: READ_FORWARD_EN -- when defined, a
//                read colliding with the other port's write returns the new
//                data; otherwise the old word is returned (read-first).
//  Ports       : clk, rst_n (async active-low)
//                clr_req_i  - request a re-clear (honoured in IDLE only)
//                busy_o     - high while clearing; port requests are dropped
//                a_*        - game-logic port: en/we/addr/din in, dout/vld out
//                b_*        - display port: as port A plus b_scan_i (sequential
//                             read mode) and b_wrap_o (last-word marker)
//  Revision    : 1.0  initial release
// ============================================================================
module maze_dpram_ctrl
    import maze_mem_pkg::*;
#(
    parameter int                 DATA_W   = MAZE_DATA_W,
    parameter int                 ADDR_W   = MAZE_ADDR_W,
    parameter int                 DEPTH    = MAZE_DEPTH,
    parameter logic [DATA_W-1:0]  FILL_VAL = '0,
    parameter int                 RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req_i,
    output logic              busy_o,
    input  logic              a_en_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_din_i,
    output logic [DATA_W-1:0] a_dout_o,
    output logic              a_vld_o,
    input  logic              b_en_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_din_i,
    input  logic              b_scan_i,
    output logic [DATA_W-1:0] b_dout_o,
    output logic              b_vld_o,
    output logic              b_wrap_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
    endfunction

    // ------------------------------------------------------------------
    // FSM, clear counter and scan counter
    // ------------------------------------------------------------------
    maze_state_e       state_q;
    logic              busy_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [ADDR_W-1:0] scan_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            busy_q     <= 1'b1;
            clr_cnt_q  <= '0;
            scan_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    scan_cnt_q <= '0;
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (b_scan_i) begin
                        scan_cnt_q <= (scan_cnt_q == LAST_ADDR) ? '0 : scan_cnt_q + 1'b1;
                    end
                    if (clr_req_i) begin
                        state_q   <= ST_CLEAR;
                        busy_q    <= 1'b1;
                        clr_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign busy_o = busy_q;

    // ------------------------------------------------------------------
    // Request qualification and collision resolution
    // ------------------------------------------------------------------
    logic              w_idle;
    logic              w_clearing;
    logic              w_a_inr;
    logic              w_a_rd;
    logic              w_a_wr;
    logic [ADDR_W-1:0] w_b_addr;
    logic              w_b_inr;
    logic              w_b_rd;
    logic              w_b_wr;
    logic              w_scan_rd;

    assign w_idle     = (state_q == ST_IDLE);
    assign w_clearing = (state_q == ST_CLEAR);

    assign w_a_inr = in_range(a_addr_i);
    assign w_a_rd  = w_idle & a_en_i & ~a_we_i;
    assign w_a_wr  = w_idle & a_en_i & a_we_i & w_a_inr;

    assign w_scan_rd = w_idle & b_scan_i;
    assign w_b_addr  = b_scan_i ? scan_cnt_q : b_addr_i;
    assign w_b_inr   = in_range(w_b_addr);
    assign w_b_rd    = w_scan_rd | (w_idle & ~b_scan_i & b_en_i & ~b_we_i);
    // Port B's write is dropped when port A writes the same word
    assign w_b_wr    = w_idle & ~b_scan_i & b_en_i & b_we_i & w_b_inr &
                       ~(w_a_wr & (a_addr_i == b_addr_i));

    logic              w_a_fwd;
    logic [DATA_W-1:0] w_a_fwd_data;
    logic              w_b_fwd;
    logic [DATA_W-1:0] w_b_fwd_data;

`ifdef READ_FORWARD_EN
    // Write-through: the reader sees what the other port stores this cycle
    assign w_a_fwd      = w_a_rd & w_b_wr & (a_addr_i == w_b_addr);
    assign w_a_fwd_data = b_din_i;
    assign w_b_fwd      = w_b_rd & w_a_wr & (w_b_addr == a_addr_i);
    assign w_b_fwd_data = a_din_i;
`else
    assign w_a_fwd      = 1'b0;
    assign w_a_fwd_data = '0;
    assign w_b_fwd      = 1'b0;
    assign w_b_fwd_data = '0;
`endif

    // ------------------------------------------------------------------
    // RAM core; port A is borrowed by the clear engine while clearing
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_a_rdata;
    logic [DATA_W-1:0] w_b_rdata;

    maze_dpram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk       (clk),
        .a_re_i    (w_a_rd & w_a_inr),
        .a_we_i    (w_clearing | w_a_wr),
        .a_addr_i  (w_clearing ? clr_cnt_q : a_addr_i),
        .a_wdata_i (w_clearing ? FILL_VAL : a_din_i),
        .a_rdata_o (w_a_rdata),
        .b_re_i    (w_b_rd & w_b_inr),
        .b_we_i    (w_b_wr),
        .b_addr_i  (w_b_addr),
        .b_wdata_i (b_din_i),
        .b_rdata_o (w_b_rdata)
    );

    // ------------------------------------------------------------------
    // First read stage: side-band flags travelling with the RAM output.
    // The zero flags come out of reset set, so the data outputs read 0
    // before any read has happened even though the RAM register is unreset.
    // ------------------------------------------------------------------
    logic              a_vld1_q, a_zero1_q, a_fwd1_q;
    logic [DATA_W-1:0] a_fwd1_data_q;
    logic              b_vld1_q, b_zero1_q, b_fwd1_q, b_wrap1_q;
    logic [DATA_W-1:0] b_fwd1_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld1_q      <= 1'b0;
            a_zero1_q     <= 1'b1;
            a_fwd1_q      <= 1'b0;
            a_fwd1_data_q <= '0;
            b_vld1_q      <= 1'b0;
            b_zero1_q     <= 1'b1;
            b_fwd1_q      <= 1'b0;
            b_fwd1_data_q <= '0;
            b_wrap1_q     <= 1'b0;
        end else begin
            a_vld1_q  <= w_a_rd;
            b_vld1_q  <= w_b_rd;
            b_wrap1_q <= w_scan_rd & (scan_cnt_q == LAST_ADDR);
            if (w_a_rd) begin
                a_zero1_q     <= ~w_a_inr;
                a_fwd1_q      <= w_a_fwd;
                a_fwd1_data_q <= w_a_fwd_data;
            end
            if (w_b_rd) begin
                b_zero1_q     <= ~w_b_inr;
                b_fwd1_q      <= w_b_fwd;
                b_fwd1_data_q <= w_b_fwd_data;
            end
        end
    end

    logic [DATA_W-1:0] w_a_dout1;
    logic [DATA_W-1:0] w_b_dout1;

    assign w_a_dout1 = a_zero1_q ? '0 : (a_fwd1_q ? a_fwd1_data_q : w_a_rdata);
    assign w_b_dout1 = b_zero1_q ? '0 : (b_fwd1_q ? b_fwd1_data_q : w_b_rdata);

    // ------------------------------------------------------------------
    // Optional second output register
    // ------------------------------------------------------------------
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] a_dout2_q, b_dout2_q;
            logic              a_vld2_q, b_vld2_q, b_wrap2_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_dout2_q <= '0;
                    b_dout2_q <= '0;
                    a_vld2_q  <= 1'b0;
                    b_vld2_q  <= 1'b0;
                    b_wrap2_q <= 1'b0;
                end else begin
                    a_dout2_q <= w_a_dout1;
                    b_dout2_q <= w_b_dout1;
                    a_vld2_q  <= a_vld1_q;
                    b_vld2_q  <= b_vld1_q;
                    b_wrap2_q <= b_wrap1_q;
                end
            end

            assign a_dout_o = a_dout2_q;
            assign a_vld_o  = a_vld2_q;
            assign b_dout_o = b_dout2_q;
            assign b_vld_o  = b_vld2_q;
            assign b_wrap_o = b_wrap2_q;
        end else begin : g_lat1
            assign a_dout_o = w_a_dout1;
            assign a_vld_o  = a_vld1_q;
            assign b_dout_o = w_b_dout1;
            assign b_vld_o  = b_vld1_q;
            assign b_wrap_o = b_wrap1_q;
        end
    endgenerate

endmodule : maze_dpram_ctrl
`default_nettype wire

// File: tb/tb_maze_dpram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maze_dpram_ctrl
//  Description : Self-checking bench for maze_dpram_ctrl (DEPTH=512, RD_LAT=1,
//                non-zero fill value). Table-driven port accesses plus
//                hand-written clear, scan and reset-during-clear sequences.
//                Honours READ_FORWARD_EN for the collision expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_maze_dpram_ctrl;

    localparam int          DATA_W = 16;
    localparam int          ADDR_W = 9;
    localparam int          DEPTH  = 512;
    localparam logic [15:0] FILL   = 16'h5A5A;
`ifdef READ_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr_req;
    logic              busy;
    logic              a_en, a_we, a_vld;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_din, a_dout;
    logic              b_en, b_we, b_scan, b_vld, b_wrap;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_din, b_dout;

    always #5 clk = ~clk;

    maze_dpram_ctrl #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .FILL_VAL (FILL),
        .RD_LAT   (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req_i (clr_req),
        .busy_o    (busy),
        .a_en_i    (a_en),
        .a_we_i    (a_we),
        .a_addr_i  (a_addr),
        .a_din_i   (a_din),
        .a_dout_o  (a_dout),
        .a_vld_o   (a_vld),
        .b_en_i    (b_en),
        .b_we_i    (b_we),
        .b_addr_i  (b_addr),
        .b_din_i   (b_din),
        .b_scan_i  (b_scan),
        .b_dout_o  (b_dout),
        .b_vld_o   (b_vld),
        .b_wrap_o  (b_wrap)
    );

    int chk_cnt  = 0;
    int fail_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        a_en;
        logic        a_we;
        logic [8:0]  a_addr;
        logic [15:0] a_din;
        logic        b_en;
        logic        b_we;
        logic [8:0]  b_addr;
        logic [15:0] b_din;
        logic        ea_vld;
        logic [15:0] ea_dout;
        logic        eb_vld;
        logic [15:0] eb_dout;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic idle_inputs();
        a_en = 0; a_we = 0; a_addr = '0; a_din = '0;
        b_en = 0; b_we = 0; b_addr = '0; b_din = '0;
        b_scan = 0; clr_req = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts cycles until busy drops; fails on a timeout or any vld during clear
    task automatic wait_clear(input string name, input bit stop_early_at_100, output int cyc);
        int vld_bad;
        cyc     = 0;
        vld_bad = 0;
        while (busy && cyc < 2000 && !(stop_early_at_100 && cyc == 100)) begin
            tick();
            cyc++;
            if (cyc == 20) clr_req = 0;
            if (busy && (a_vld || b_vld)) vld_bad++;
        end
        check({name, "_vld_during_busy"}, vld_bad, 0);
    endtask

    initial begin
        int cyc;
        int wraps;
        logic [15:0] exp_d;

        idle_inputs();
        rst_n = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_busy",   busy, 1);
        check("rst_outs",   {a_vld, b_vld, b_wrap}, 0);
        check("rst_a_dout", a_dout, 0);
        check("rst_b_dout", b_dout, 0);

        // ---------------- initial clear ----------------
        // Requests and a clr_req during clear must all be ignored
        a_en = 1; a_we = 1; a_addr = 9'd1; a_din = 16'hDEAD;
        b_en = 1; b_we = 0; b_addr = 9'd3;
        clr_req = 1;
        rst_n = 1'b1;
        wait_clear("clr0", 1'b0, cyc);
        check("clr0_cycles", cyc, DEPTH);
        idle_inputs();

        // ---------------- table-driven accesses ----------------
        vecs[0]  = '{1,0,9'h001,16'h0000, 0,0,9'h000,16'h0000, 1,FILL,     0,16'h0};
        vecs[1]  = '{1,0,9'h0FF,16'h0000, 1,0,9'h1FF,16'h0000, 1,FILL,     1,FILL};
        vecs[2]  = '{1,0,9'h1FF,16'h0000, 1,0,9'h1FF,16'h0000, 1,FILL,     1,FILL};
        vecs[3]  = '{1,1,9'h010,16'hBEEF, 0,0,9'h000,16'h0000, 0,16'h0,    0,16'h0};
        vecs[4]  = '{0,0,9'h000,16'h0000, 1,0,9'h010,16'h0000, 0,16'h0,    1,16'hBEEF};
        vecs[5]  = '{1,1,9'h020,16'h1111, 1,1,9'h020,16'h2222, 0,16'h0,    0,16'h0};
        vecs[6]  = '{1,0,9'h020,16'h0000, 1,0,9'h020,16'h0000, 1,16'h1111, 1,16'h1111};
        vecs[7]  = '{1,1,9'h030,16'h3333, 1,0,9'h030,16'h0000, 0,16'h0,    1,(FWD ? 16'h3333 : FILL)};
        vecs[8]  = '{1,0,9'h030,16'h0000, 0,0,9'h000,16'h0000, 1,16'h3333, 0,16'h0};
        vecs[9]  = '{1,0,9'h040,16'h0000, 1,1,9'h040,16'h4444, 1,(FWD ? 16'h4444 : FILL), 0,16'h0};
        vecs[10] = '{1,0,9'h040,16'h0000, 1,0,9'h040,16'h0000, 1,16'h4444, 1,16'h4444};
        vecs[11] = '{1,1,9'h042,16'h8888, 1,1,9'h041,16'h7777, 0,16'h0,    0,16'h0};
        vecs[12] = '{1,0,9'h041,16'h0000, 1,0,9'h042,16'h0000, 1,16'h7777, 1,16'h8888};
        vecs[13] = '{0,1,9'h041,16'hFFFF, 0,1,9'h042,16'hFFFF, 0,16'h0,    0,16'h0};
        vecs[14] = '{1,0,9'h041,16'h0000, 1,0,9'h042,16'h0000, 1,16'h7777, 1,16'h8888};

        for (int i = 0; i < NVEC; i++) begin
            a_en = vecs[i].a_en; a_we = vecs[i].a_we; a_addr = vecs[i].a_addr; a_din = vecs[i].a_din;
            b_en = vecs[i].b_en; b_we = vecs[i].b_we; b_addr = vecs[i].b_addr; b_din = vecs[i].b_din;
            tick();
            check($sformatf("vec%0d_a_vld", i), a_vld, vecs[i].ea_vld);
            check($sformatf("vec%0d_b_vld", i), b_vld, vecs[i].eb_vld);
            if (vecs[i].ea_vld) check($sformatf("vec%0d_a_dout", i), a_dout, vecs[i].ea_dout);
            if (vecs[i].eb_vld) check($sformatf("vec%0d_b_dout", i), b_dout, vecs[i].eb_dout);
        end
        idle_inputs();

        // ---------------- scan mode ----------------
        for (int k = 0; k < DEPTH; k++) begin
            a_en = 1; a_we = 1; a_addr = 9'(k); a_din = 16'(k);
            tick();
        end
        idle_inputs();

        b_scan = 1;
        wraps  = 0;
        for (int i = 0; i < 1030; i++) begin
            tick();
            exp_d = 16'(i % DEPTH);
            check($sformatf("scan%0d", i), {b_vld, b_wrap, b_dout},
                  {1'b1, (exp_d == 16'd511), exp_d});
            if (b_wrap) wraps++;
        end
        check("scan_wrap_count", wraps, 2);

        // scan paused: no read, counter holds at 1030 mod 512 = 6
        b_scan = 0;
        tick();
        check("scan_pause_vld", b_vld, 0);
        b_scan = 1;
        tick();
        check("scan_resume", {b_vld, b_dout}, {1'b1, 16'd6});

        // ---------------- clr_req mid-scan, then reset mid-clear ----------------
        clr_req = 1;
        tick();
        check("clrreq_served", {b_vld, b_dout}, {1'b1, 16'd7});
        check("clrreq_busy", busy, 1);
        clr_req = 0;
        a_en = 1; a_we = 1; a_addr = 9'd300; a_din = 16'hDEAD;
        wait_clear("clr1", 1'b1, cyc);
        check("clr1_still_busy", busy, 1);

        rst_n = 1'b0;
        #2;
        check("midclr_rst_busy", busy, 1);
        check("midclr_rst_outs", {a_vld, b_vld, b_wrap, a_dout, b_dout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear("clr2", 1'b0, cyc);
        check("clr2_cycles", cyc, DEPTH);

        // scan restarts at 0; everything back at fill value
        a_en = 1; a_we = 0; a_addr = 9'd300;
        tick();
        check("post_clr_scan0", {b_vld, b_wrap, b_dout}, {1'b1, 1'b0, FILL});
        check("post_clr_a300",  {a_vld, a_dout}, {1'b1, FILL});
        a_addr = 9'd7;
        tick();
        check("post_clr_a7", {a_vld, a_dout}, {1'b1, FILL});
        idle_inputs();
        tick();
        check("post_clr_idle", {a_vld, b_vld}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
        $finish;
    end

endmodule : tb_maze_dpram_ctrl
`default_nettype wire
